// File: rtl/lsp_enc_pkg.sv
// lsp_enc_pkg: shared constants, codebook layout and FSM states for the LSP scalar encoder
package lsp_enc_pkg;
  localparam logic [31:0] RADTOHZ = 32'h04F93D52;
  localparam int CB_SIZE [10] = '{16, 16, 16, 16, 16, 16, 16, 8, 8, 4};
  localparam int CB_BASE [10] = '{0, 16, 32, 48, 64, 80, 96, 112, 120, 128};
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LSP,
    S_LAT,
    S_CONV,
    S_SEARCH,
    S_STORE,
    S_DONE
  } state_t;
endpackage

// File: rtl/lsp_sq_err_cmp.sv
// lsp_sq_err_cmp: squared-error nearest-neighbour tracker, keeps lowest index on ties
//   i_init   : reset best error to all-ones and best index to 0
//   i_en     : compare i_cb (entry i_j) against i_hz this cycle
//   o_best_j : index of the closest entry seen since i_init
module lsp_sq_err_cmp #(
  parameter int N = 32,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_init,
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_j,
  input  logic [N-1:0]     i_hz,
  input  logic [N-1:0]     i_cb,
  output logic [IDX_W-1:0] o_best_j
);
  logic signed [N:0] w_diff;
  logic [2*N+1:0]    w_sq;
  logic [2*N+1:0]    r_best_err;
  // N+1-bit difference and 2N+2-bit square can never wrap, even for full-scale inputs
  assign w_diff = $signed({i_hz[N-1], i_hz}) - $signed({i_cb[N-1], i_cb});
  assign w_sq = w_diff * w_diff;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best_err <= '1;
      o_best_j <= '0;
    end else if (i_init) begin
      r_best_err <= '1;
      o_best_j <= '0;
    end else if (i_en && w_sq < r_best_err) begin
      r_best_err <= w_sq;
      o_best_j <= i_j;
    end
  end
endmodule

// File: rtl/qmult.sv
// qmult: signed fixed-point multiply, full-width product shifted by Q and truncated to N bits
//   i_a, i_b : signed QN operands
//   o_r      : (i_a*i_b)>>>Q truncated to N bits
module qmult #(
  parameter int Q = 16,
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_r
);
  logic signed [2*N-1:0] w_p;
  assign w_p = $signed(i_a) * $signed(i_b);
  assign o_r = N'(w_p >>> Q);
endmodule

// File: rtl/lsp_scalar_encoder.sv
// lsp_scalar_encoder: full-frame LSP scalar quantiser sequencer (rad->Hz, codebook NN search)
//   start/hz_bypass : frame request and Hz-input mode, sampled in IDLE
//   busy/done       : frame in progress / one-cycle completion pulse
//   lsp_addr/rdata  : LSP store port, 1-cycle latency
//   cb_addr/rdata   : codebook ROM port, 1-cycle latency
//   idx_*           : per-LSP result pulse; indexes holds the packed frame
module lsp_scalar_encoder
  import lsp_enc_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 16,
  parameter int ORDER = 10,
  parameter int IDX_W = 4,
  parameter int CB_AW = 8,
  parameter int LSP_AW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   hz_bypass,
  output logic                   busy,
  output logic                   done,
  output logic [LSP_AW-1:0]      lsp_addr,
  input  logic [N-1:0]           lsp_rdata,
  output logic [CB_AW-1:0]       cb_addr,
  input  logic [N-1:0]           cb_rdata,
  output logic                   idx_valid,
  output logic [LSP_AW-1:0]      idx_order,
  output logic [IDX_W-1:0]       idx_value,
  output logic [ORDER*IDX_W-1:0] indexes
);
  state_t            r_state;
  logic [LSP_AW-1:0] r_i;
  logic [IDX_W:0]    r_k;
  logic              r_byp;
  logic [N-1:0]      r_lsp;
  logic [N-1:0]      r_hz;
  logic [N-1:0]      w_conv;
  logic [IDX_W:0]    w_m;
  logic [IDX_W-1:0]  w_best_j;
  assign w_m = (IDX_W+1)'(CB_SIZE[r_i]);
  qmult #(.Q(Q), .N(N)) u_qmult (
    .i_a(r_lsp),
    .i_b(N'(RADTOHZ)),
    .o_r(w_conv)
  );
  // SEARCH cycle k compares entry k-1, whose address was driven in cycle k-1
  lsp_sq_err_cmp #(.N(N), .IDX_W(IDX_W)) u_cmp (
    .clk(clk),
    .rst(rst),
    .i_init(r_state == S_CONV),
    .i_en(r_state == S_SEARCH && r_k != '0),
    .i_j(IDX_W'(r_k - 1'b1)),
    .i_hz(r_hz),
    .i_cb(cb_rdata),
    .o_best_j(w_best_j)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_i <= '0;
      r_k <= '0;
      r_byp <= 1'b0;
      r_lsp <= '0;
      r_hz <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      lsp_addr <= '0;
      cb_addr <= '0;
      idx_valid <= 1'b0;
      idx_order <= '0;
      idx_value <= '0;
      indexes <= '0;
    end else begin
      done <= 1'b0;
      idx_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          indexes <= '0;
          r_byp <= hz_bypass;
          r_i <= '0;
          lsp_addr <= '0;
          busy <= 1'b1;
          r_state <= S_RD_LSP;
        end
        S_RD_LSP: r_state <= S_LAT;
        S_LAT: begin
          r_lsp <= lsp_rdata;
          r_state <= S_CONV;
        end
        S_CONV: begin
          r_hz <= r_byp ? r_lsp : w_conv;
          cb_addr <= CB_AW'(CB_BASE[r_i]);
          r_k <= '0;
          r_state <= S_SEARCH;
        end
        S_SEARCH: begin
          r_k <= r_k + 1'b1;
          if (r_k + 1'b1 < w_m) cb_addr <= cb_addr + 1'b1;
          if (r_k == w_m) r_state <= S_STORE;
        end
        S_STORE: begin
          indexes[r_i*IDX_W +: IDX_W] <= w_best_j;
          idx_valid <= 1'b1;
          idx_order <= r_i;
          idx_value <= w_best_j;
          if (r_i == LSP_AW'(ORDER - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_i <= r_i + 1'b1;
            lsp_addr <= r_i + 1'b1;
            r_state <= S_RD_LSP;
          end
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
